// File: rtl/btn_step_counter.sv
// Debounced up/down button counter driving a 3-bit seven-segment display code.
// Code 3'b100 (shown as 'E') is held while both buttons are down.
module btn_step_counter #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_VAL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] cnt,
  output logic       err
);

  localparam int            CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [2:0]    MAX_CODE = 3'(MAX_VAL);
  localparam logic [2:0]    ERR_CODE = 3'b100;

  typedef enum logic {ST_COUNT, ST_ERROR} state_t;

  // Bit 0 carries the up button, bit 1 the down button throughout.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_prev_q, deb_prev_d;
  logic [1:0][CW-1:0] dcnt_q, dcnt_d;
  logic [1:0]         press;
  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  always_comb begin
    sync1_d    = {btn_down, btn_up};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    dcnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CW'(1);
        end
      end
    end
    press = deb_q & ~deb_prev_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_COUNT: begin
        // Both held beats any press event seen on the same cycle.
        if (&deb_q) begin
          state_d = ST_ERROR;
          cnt_d   = ERR_CODE;
          err_d   = 1'b1;
        end else if (press == 2'b01) begin
          cnt_d = (cnt_q == MAX_CODE) ? 3'd0 : cnt_q + 3'd1;
        end else if (press == 2'b10) begin
          cnt_d = (cnt_q == 3'd0) ? MAX_CODE : cnt_q - 3'd1;
        end
      end
      ST_ERROR: begin
        if (deb_q == 2'b00) begin
          state_d = ST_COUNT;
          cnt_d   = 3'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_COUNT;
        cnt_d   = 3'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q     <= '0;
      state_q    <= ST_COUNT;
      cnt_q      <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dcnt_q     <= dcnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: tb/tb_btn_step_counter.sv
// Bench for btn_step_counter: directed scenarios plus random button activity,
// every cycle compared against a window-based reference of the button rules.
`timescale 1ns/1ps
module tb_btn_step_counter;

  localparam int DEB = 4;
  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       bu;
  logic       bd;
  logic [2:0] cnt;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: raw history per button (index 0 = newest edge sample).
  bit hist [2][8];
  bit dcur [2];
  bit dprev[2];
  int mcnt;
  bit merr;

  btn_step_counter #(.DEB_CYCLES(DEB), .MAX_VAL(MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (bu),
    .btn_down (bd),
    .cnt      (cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 8; j++) hist[b][j] = 1'b0;
      dcur[b]  = 1'b0;
      dprev[b] = 1'b0;
    end
    mcnt = 0;
    merr = 1'b0;
  endtask

  // A debounced level flips once the raw value seen DEB edges in a row
  // (after the two-edge synchronizer delay) disagrees with it.
  task automatic model_edge(input bit u, input bit d);
    bit r[2];
    bit lvl[2];
    bit ev[2];
    bit flip;
    r[0] = u;
    r[1] = d;
    for (int b = 0; b < 2; b++) begin
      for (int j = 7; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = r[b];
      lvl[b] = dcur[b];
      ev[b]  = dcur[b] && !dprev[b];
      flip = 1'b1;
      for (int j = 2; j < DEB + 2; j++) if (hist[b][j] == dcur[b]) flip = 1'b0;
      dprev[b] = dcur[b];
      if (flip) dcur[b] = !dcur[b];
    end
    if (!merr) begin
      if (lvl[0] && lvl[1])       merr = 1'b1;
      else if (ev[0] && !ev[1])   mcnt = (mcnt + 1) % (MAX + 1);
      else if (ev[1] && !ev[0])   mcnt = (mcnt + MAX) % (MAX + 1);
    end else if (!lvl[0] && !lvl[1]) begin
      merr = 1'b0;
      mcnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bu, bd);
    #1;
    check_eq("cnt", cnt, merr ? 32'd4 : mcnt);
    check_eq("err", err, merr);
  endtask

  task automatic hold(input bit u, input bit d, input int n);
    bu = u;
    bd = d;
    repeat (n) tick();
  endtask

  task automatic press_up();
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic press_down();
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  // Called just after a clock edge; checks the asynchronous clear before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("async_rst_cnt", cnt, 0);
    check_eq("async_rst_err", err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Holds up for 20 cycles and reports the first edge where cnt moved.
  task automatic measure_up(output int first, output int changes);
    logic [2:0] prev;
    first   = 0;
    changes = 0;
    prev    = cnt;
    bu = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cnt !== prev) begin
        if (first == 0) first = i;
        changes++;
        prev = cnt;
      end
    end
    hold(1'b0, 1'b0, 10);
  endtask

  initial begin
    int first;
    int changes;
    int rem_u;
    int rem_d;

    rst = 1'b1;
    bu  = 1'b0;
    bd  = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_cnt", cnt, 0);
    check_eq("reset_err", err, 0);
    rst = 1'b0;
    hold(1'b0, 1'b0, 3);

    measure_up(first, changes);
    check_eq("latency", first, DEB + 3);
    check_eq("single_change", changes, 1);
    check_eq("after_press", cnt, 1);

    bu = 1'b1; tick();
    bu = 1'b0; tick();
    bu = 1'b1; tick();
    bu = 1'b0; tick();
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 10);
    check_eq("bounce", cnt, 2);

    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 12);
    check_eq("glitch", cnt, 2);

    do_reset();
    hold(1'b0, 1'b0, 2);

    press_up();   check_eq("up1", cnt, 1);
    press_up();   check_eq("up2", cnt, 2);
    press_up();   check_eq("up3", cnt, 3);
    press_up();   check_eq("up_wrap", cnt, 0);
    press_down(); check_eq("down_wrap", cnt, 3);

    hold(1'b1, 1'b0, 10);
    check_eq("hold_up", cnt, 0);
    hold(1'b1, 1'b1, 10);
    check_eq("err_cnt", cnt, 4);
    check_eq("err_flag", err, 1);
    hold(1'b0, 1'b1, 12);
    check_eq("half_release", err, 1);
    hold(1'b0, 1'b0, 12);
    check_eq("exit_cnt", cnt, 0);
    check_eq("exit_err", err, 0);
    press_up();
    check_eq("post_err", cnt, 1);

    hold(1'b1, 1'b1, 12);
    check_eq("same_edge_err", err, 1);
    check_eq("same_edge_cnt", cnt, 4);
    hold(1'b0, 1'b0, 12);
    check_eq("same_edge_exit", cnt, 0);

    bu = 1'b1;
    hold(1'b1, 1'b0, 4);
    do_reset();
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cnt !== 3'd0 && first == 0) first = i;
    end
    check_eq("held_reset_lat", first, DEB + 3);
    hold(1'b0, 1'b0, 10);

    rem_u = 0;
    rem_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rem_u == 0) begin
        bu = ~bu;
        rem_u = bu ? $urandom_range(1, 10) : $urandom_range(1, 16);
      end
      if (rem_d == 0) begin
        bd = ~bd;
        rem_d = bd ? $urandom_range(1, 10) : $urandom_range(1, 24);
      end
      rem_u--;
      rem_d--;
      tick();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
